frontend_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares the memory controller's single frontend command port (command / valid / write_data, with ba_cmd_pm flow control) between NUM_REQ requesters, such as the weight loader, activation writer and readback engine. It issues one granted command per cycle while the controller grants permission. It records the requester ID of every read in an in-order tag FIFO, and routes each returning read_data beat back to the requester that issued that read. It sits directly between the requester fabric and the Command_Scheduler frontend.

---
 rtl/frontend_cmd_arbiter_if.sv | 14 +
 rtl/frontend_cmd_arbiter.sv | 115 +++++++++++
 tb/tb_frontend_cmd_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/frontend_cmd_arbiter_if.sv
// frontend_cmd_arbiter_if: controller-side frontend command port (command/valid/write_data out, permission and read data back)
interface frontend_cmd_arbiter_if #(
  parameter int CMD_BITS  = 32,
  parameter int DATA_BITS = 64
);
  logic [CMD_BITS-1:0]  command;
  logic                 valid;
  logic [DATA_BITS-1:0] write_data;
  logic                 ba_cmd_pm;
  logic [DATA_BITS-1:0] read_data;
  logic                 read_data_valid;
  modport master (output command, valid, write_data, input ba_cmd_pm, read_data, read_data_valid);
  modport slave  (input command, valid, write_data, output ba_cmd_pm, read_data, read_data_valid);
endinterface

// File: rtl/frontend_cmd_arbiter.sv
// frontend_cmd_arbiter: round-robin share of the controller frontend port with in-order read tag routing
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 32
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif
`ifndef OP_READ
`define OP_READ 2'd1
`endif
`ifndef OP_WRITE
`define OP_WRITE 2'd2
`endif
module frontend_cmd_arbiter #(
  parameter int              NUM_REQ      = 3,
  parameter int              CMD_BITS     = `FRONTEND_CMD_BITS,
  parameter int              DATA_BITS    = `DQ_BITS*8,
  parameter int              OP_POS       = CMD_BITS-2,
  parameter int              OP_W         = 2,
  parameter logic [OP_W-1:0] OP_READ_VAL  = `OP_READ,
  parameter logic [OP_W-1:0] OP_WRITE_VAL = `OP_WRITE,
  parameter int              TAG_DEPTH    = 16
) (
  input  logic                           clk,
  input  logic                           power_on_rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*CMD_BITS-1:0]    req_cmd,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  frontend_cmd_arbiter_if.master         fe,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_BITS-1:0]           rsp_data,
  output logic [$clog2(TAG_DEPTH+1)-1:0] rd_outstanding,
  output logic                           err_orphan_rsp
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TAG_DEPTH+1);
  localparam int AW = $clog2(TAG_DEPTH);
  logic [NUM_REQ-1:0]   is_read, is_write, elig;
  logic                 full, gnt, push, pop;
  int                   idx;
  logic [PW-1:0]        gnt_idx, rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        tag_mem_q [TAG_DEPTH];
  logic [CMD_BITS-1:0]  command_q, command_d;
  logic                 valid_q, valid_d, err_q, err_d;
  logic [DATA_BITS-1:0] write_data_q, write_data_d, rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  always_comb begin
    full = cnt_q == CW'(TAG_DEPTH);
    for (int i = 0; i < NUM_REQ; i++) begin
      is_read[i]  = req_cmd[i*CMD_BITS+OP_POS +: OP_W] == OP_READ_VAL;
      is_write[i] = req_cmd[i*CMD_BITS+OP_POS +: OP_W] == OP_WRITE_VAL;
      elig[i]     = req_valid[i] & (~is_read[i] | ~full);
    end
    gnt = 1'b0;
    gnt_idx = '0;
    idx = 0;
    // Walk from the farthest offset down so the candidate closest to rr_ptr wins.
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k >= NUM_REQ ? int'(rr_ptr_q) + k - NUM_REQ : int'(rr_ptr_q) + k;
      gnt_idx = fe.ba_cmd_pm && elig[idx] ? PW'(idx) : gnt_idx;
      gnt = gnt | (fe.ba_cmd_pm & elig[idx]);
    end
    req_ready = gnt ? NUM_REQ'(1) << gnt_idx : '0;
    push = gnt & is_read[gnt_idx];
    pop = fe.read_data_valid & (cnt_q != '0);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    rr_ptr_d = !gnt ? rr_ptr_q : gnt_idx == PW'(NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
    command_d = gnt ? req_cmd[gnt_idx*CMD_BITS +: CMD_BITS] : '0;
    valid_d = gnt;
    write_data_d = gnt && is_write[gnt_idx] ? req_wdata[gnt_idx*DATA_BITS +: DATA_BITS] : '0;
    rsp_valid_d = pop ? NUM_REQ'(1) << tag_mem_q[rd_ptr_q] : '0;
    rsp_data_d = pop ? fe.read_data : rsp_data_q;
    err_d = err_q | (fe.read_data_valid & (cnt_q == '0));
  end
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
  end
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      command_q    <= '0;
      valid_q      <= 1'b0;
      write_data_q <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      command_q    <= command_d;
      valid_q      <= valid_d;
      write_data_q <= write_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
    end
  end
  assign fe.command     = command_q;
  assign fe.valid       = valid_q;
  assign fe.write_data  = write_data_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rd_outstanding = cnt_q;
  assign err_orphan_rsp = err_q;
endmodule

// File: tb/tb_frontend_cmd_arbiter.sv
// tb_frontend_cmd_arbiter: table vectors, directed corner sequences and random traffic against a queue-based reference model
module tb_frontend_cmd_arbiter;
  localparam int N = 3, CB = 32, DB = 64, TD = 16;
  localparam logic [1:0] RD = 2'd1, WR = 2'd2;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*CB-1:0] req_cmd;
  logic [N*DB-1:0] req_wdata;
  logic [DB-1:0]   rsp_data;
  logic [4:0]      rd_outstanding;
  logic            err_orphan_rsp;
  frontend_cmd_arbiter_if #(.CMD_BITS(CB), .DATA_BITS(DB)) fe ();
  frontend_cmd_arbiter #(.NUM_REQ(N), .CMD_BITS(CB), .DATA_BITS(DB), .OP_POS(CB-2), .OP_W(2),
    .OP_READ_VAL(RD), .OP_WRITE_VAL(WR), .TAG_DEPTH(TD)) dut (
    .clk(clk), .power_on_rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_wdata(req_wdata), .req_ready(req_ready), .fe(fe), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rd_outstanding(rd_outstanding), .err_orphan_rsp(err_orphan_rsp));
  // Stimulus state
  logic [1:0]    op [N];
  logic [29:0]   pay [N];
  logic [DB-1:0] wd [N];
  logic [N-1:0]  vld;
  logic          ba, rdv;
  logic [DB-1:0] rdata;
  // Reference model: tags in flight as a queue, pointer as a plain integer
  int q[$];
  int rr;
  logic [CB-1:0] e_cmd;
  logic          e_valid, e_err;
  logic [DB-1:0] e_wd, e_rd;
  logic [N-1:0]  e_rv;
  int checks = 0, errors = 0;
  int gg;
  typedef struct { logic [N-1:0] vld; logic ba; logic [N-1:0] rdy; } vec_t;
  vec_t tab [10];
  task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_cmd[i*CB +: CB] = {op[i], pay[i]};
      req_wdata[i*DB +: DB] = wd[i];
    end
    req_valid = vld;
    fe.ba_cmd_pm = ba;
    fe.read_data_valid = rdv;
    fe.read_data = rdata;
  endtask
  task automatic chk_out(input string p);
    chk({p, "command"}, DB'(fe.command), DB'(e_cmd));
    chk({p, "valid"}, DB'(fe.valid), DB'(e_valid));
    chk({p, "write_data"}, fe.write_data, e_wd);
    chk({p, "rsp_valid"}, DB'(rsp_valid), DB'(e_rv));
    chk({p, "rsp_data"}, rsp_data, e_rd);
    chk({p, "rd_outstanding"}, DB'(rd_outstanding), DB'(q.size()));
    chk({p, "err_orphan_rsp"}, DB'(err_orphan_rsp), DB'(e_err));
  endtask
  // One clock: apply inputs, check the Mealy grant, advance the model, check registered outputs.
  task automatic cycle(input logic [N-1:0] tab_rdy, input bit use_tab, output int g);
    bit full;
    apply();
    #1;
    full = q.size() == TD;
    g = -1;
    if (ba) for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if (g < 0 && vld[i] && (op[i] != RD || !full)) g = i;
    end
    chk("req_ready", DB'(req_ready), g < 0 ? '0 : DB'(1) << g);
    if (use_tab) chk("req_ready_vec", DB'(req_ready), DB'(tab_rdy));
    if (rdv && q.size() > 0) begin
      e_rv = N'(1) << q[0];
      e_rd = rdata;
      void'(q.pop_front());
    end else begin
      e_rv = '0;
      if (rdv) e_err = 1'b1;
    end
    if (g >= 0) begin
      e_cmd = {op[g], pay[g]};
      e_valid = 1'b1;
      e_wd = op[g] == WR ? wd[g] : '0;
      rr = (g + 1) % N;
      if (op[g] == RD) q.push_back(g);
    end else begin
      e_cmd = '0;
      e_valid = 1'b0;
      e_wd = '0;
    end
    @(posedge clk);
    #1;
    chk_out("");
  endtask
  task automatic step();
    cycle('0, 1'b0, gg);
  endtask
  task automatic model_clear();
    q.delete();
    rr = 0;
    e_cmd = '0; e_valid = 0; e_wd = '0; e_rv = '0; e_rd = '0; e_err = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    vld = '0; rdv = 0; ba = 0; rdata = '0;
    apply();
    model_clear();
    #2;
    chk_out("rst_");
    chk("rst_req_ready", DB'(req_ready), '0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int r0, r2, row;
    tab[0] = '{3'b111, 1, 3'b001};
    tab[1] = '{3'b111, 1, 3'b010};
    tab[2] = '{3'b111, 1, 3'b100};
    tab[3] = '{3'b110, 1, 3'b010};
    tab[4] = '{3'b011, 1, 3'b001};
    tab[5] = '{3'b111, 0, 3'b000};
    tab[6] = '{3'b101, 1, 3'b100};
    tab[7] = '{3'b000, 1, 3'b000};
    tab[8] = '{3'b100, 1, 3'b100};
    tab[9] = '{3'b001, 1, 3'b001};
    for (int i = 0; i < N; i++) begin
      op[i] = WR; pay[i] = 30'(i); wd[i] = {$urandom, $urandom};
    end
    do_reset();
    // Arbitration vectors (writes only)
    foreach (tab[t]) begin
      vld = tab[t].vld; ba = tab[t].ba;
      cycle(tab[t].rdy, 1'b1, gg);
    end
    // Three requesters x 4 writes, strict rotation
    do_reset();
    ba = 1; vld = 3'b111;
    for (int i = 0; i < N; i++) wd[i] = DB'(64'h1000 * i);
    for (int k = 0; k < 12; k++) begin
      cycle(N'(1) << (k % 3), 1'b1, gg);
      if (gg >= 0) wd[gg] = wd[gg] + 1;
    end
    vld = '0;
    step();
    // Interleaved reads from req0 (rows 0..3) and req2 (rows 8..11), in-order return
    do_reset();
    ba = 1; vld = 3'b101; op[0] = RD; op[2] = RD; r0 = 0; r2 = 8;
    pay[0] = 30'(r0); pay[2] = 30'(r2);
    for (int k = 0; k < 8; k++) begin
      cycle(k % 2 ? 3'b100 : 3'b001, 1'b1, gg);
      if (gg == 0) pay[0] = 30'(++r0);
      if (gg == 2) pay[2] = 30'(++r2);
    end
    vld = '0;
    for (int k = 0; k < 8; k++) begin
      row = (k % 2 ? 8 : 0) + k / 2;
      rdv = 1; rdata = DB'(row * 16 + 5);
      step();
      chk("t2_rsp_valid", DB'(rsp_valid), k % 2 ? 4 : 1);
      chk("t2_rsp_data", rsp_data, DB'(row * 16 + 5));
    end
    rdv = 0;
    step();
    // Tag FIFO full: read stalls, write still passes, a pop unblocks only on the next cycle
    do_reset();
    ba = 1; vld = 3'b010; op[1] = RD; op[0] = WR;
    for (int k = 0; k < 16; k++) step();
    chk("t3_full_count", DB'(rd_outstanding), 16);
    vld = 3'b011;
    cycle(3'b001, 1'b1, gg);
    vld = 3'b010; rdv = 1; rdata = 64'hABCD;
    cycle(3'b000, 1'b1, gg);
    rdv = 0;
    cycle(3'b010, 1'b1, gg);
    chk("t3_refill_count", DB'(rd_outstanding), 16);
    vld = '0;
    // Permission low holds the pointer
    do_reset();
    op[1] = WR; ba = 1; vld = 3'b111;
    cycle(3'b001, 1'b1, gg);
    ba = 0;
    for (int k = 0; k < 5; k++) cycle(3'b000, 1'b1, gg);
    ba = 1;
    cycle(3'b010, 1'b1, gg);
    vld = '0;
    step();
    // Orphan response
    do_reset();
    rdv = 1; rdata = 64'h55;
    step();
    rdv = 0;
    step();
    chk("t5_orphan", DB'(err_orphan_rsp), 1);
    chk("t5_rsp_valid", DB'(rsp_valid), 0);
    chk("t5_outstanding", DB'(rd_outstanding), 0);
    // Reset with reads outstanding
    do_reset();
    ba = 1; vld = 3'b001; op[0] = RD;
    for (int k = 0; k < 5; k++) step();
    chk("t6_before_rst", DB'(rd_outstanding), 5);
    do_reset();
    ba = 1; vld = 3'b111; op[0] = WR; op[1] = WR; op[2] = WR;
    cycle(3'b001, 1'b1, gg);
    // Random traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        op[i] = 2'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 2));
        pay[i] = 30'($urandom);
        wd[i] = {$urandom, $urandom};
      end
      vld = N'($urandom);
      ba = $urandom_range(0, 3) != 0;
      rdv = $urandom_range(0, 2) == 0;
      rdata = {$urandom, $urandom};
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
